brew_sequencer: RTL

- Sequences the dispensing phases of one cup from the 2-bit mode code (M1,M0) produced by the coffee-machine mode decoder FSM.
  - Code 00: nothing.
  - Code 01: coffee without milk requested.
  - Code 10: milk requested but unavailable.
  - Code 11: coffee with milk.
- On a start request it latches the mode and drives the water, coffee and milk valves in order, each for a parameterised number of cycles.
- Reports busy, done, milk-unavailable warning and rejected-start error.
- Sits between the mode decoder and the actuator drivers.

---
 rtl/brew_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/brew_sequencer.sv
// Cup dispensing sequencer: latches the decoder mode on start and runs water/coffee/milk phases.
// Optional cups_served counter is built when BREW_CUP_COUNT_EN is defined.
module brew_sequencer #(
  parameter int T_WATER  = 20,
  parameter int T_COFFEE = 30,
  parameter int T_MILK   = 15,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       r,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] m,
  output logic       valve_agua,
  output logic       valve_cafe,
  output logic       valve_leche,
  output logic       busy,
  output logic       done,
  output logic       no_milk,
  output logic       err
`ifdef BREW_CUP_COUNT_EN
  ,
  output logic [7:0] cups_served
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WATER  = 3'd1,
    COFFEE = 3'd2,
    MILK   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LOAD_WATER  = CNT_W'(T_WATER - 1);
  localparam logic [CNT_W-1:0] LOAD_COFFEE = CNT_W'(T_COFFEE - 1);
  localparam logic [CNT_W-1:0] LOAD_MILK   = CNT_W'(T_MILK - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (m != 2'b00) begin
            mode_d  = m;
            cnt_d   = LOAD_WATER;
            state_d = WATER;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WATER: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = COFFEE;
          cnt_d   = LOAD_COFFEE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      COFFEE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          // Only mode 11 has milk available; mode 10 serves black coffee.
          if (mode_q == 2'b11) begin
            state_d = MILK;
            cnt_d   = LOAD_MILK;
          end else begin
            state_d = DONE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MILK: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    valve_agua  = (state_q == WATER);
    valve_cafe  = (state_q == COFFEE);
    valve_leche = (state_q == MILK);
    done        = (state_q == DONE);
    busy        = (state_q != IDLE);
    no_milk     = busy && (mode_q == 2'b10);
    err         = err_q;
  end

`ifdef BREW_CUP_COUNT_EN
  logic [7:0] cups_q, cups_d;

  always_comb begin
    cups_d = cups_q;
    if (state_q == DONE && cups_q != 8'hFF) begin
      cups_d = cups_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      cups_q <= 8'd0;
    end else begin
      cups_q <= cups_d;
    end
  end

  assign cups_served = cups_q;
`endif

endmodule
